tpu_simple: RTL and testbench

TPU_SIMPLE -- requirements
Module: tpu_simple

---
 rtl/tpu_simple.sv | 187 ++++++++++++++++++
 tb/tb_tpu_simple.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_simple.sv
// -----------------------------------------------------------------------------
// tpu_simple
//
// Small matrix-multiply engine. On start it latches two SIZE x SIZE signed
// operand matrices and an active dimension n, then computes C = A x B over the
// top-left n x n block using a SIZE x SIZE array of accumulators, one rank-1
// update (one value of k) per clock. Cells outside the active block stay 0.
//
// Sequence: IDLE -> LOAD (1 cycle) -> COMPUTE (n cycles) -> FINISH (1 cycle)
//           -> IDLE. With n = 0, LOAD goes straight to FINISH.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin a multiply; only looked at in IDLE
//   matrix_size  : requested dimension n (unsigned), clamped to SIZE
//   matrix_a     : operand A, row-major [row][col], signed DATA_WIDTH
//   matrix_b     : operand B, row-major [row][col], signed DATA_WIDTH
//   matrix_c     : result C, row-major, signed ACC_WIDTH, wired to accumulators
//   busy         : high in LOAD and COMPUTE
//   done         : one-cycle pulse in FINISH
// -----------------------------------------------------------------------------
module tpu_simple #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic        [7:0]            matrix_size,
  input  logic signed [DATA_WIDTH-1:0] matrix_a [0:SIZE-1][0:SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] matrix_b [0:SIZE-1][0:SIZE-1],
  output logic signed [ACC_WIDTH-1:0]  matrix_c [0:SIZE-1][0:SIZE-1],
  output logic                         busy,
  output logic                         done
);

  // IDX_W holds values 0..SIZE (ne and the post-increment k); KW addresses
  // rows/columns 0..SIZE-1.
  localparam int IDX_W = $clog2(SIZE + 1);
  localparam int KW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [7:0] SIZE_8 = 8'(SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            ne_q, ne_d;
  logic [IDX_W-1:0]            k_q, k_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic signed [DATA_WIDTH-1:0] a_q   [0:SIZE-1][0:SIZE-1];
  logic signed [DATA_WIDTH-1:0] a_d   [0:SIZE-1][0:SIZE-1];
  logic signed [DATA_WIDTH-1:0] b_q   [0:SIZE-1][0:SIZE-1];
  logic signed [DATA_WIDTH-1:0] b_d   [0:SIZE-1][0:SIZE-1];
  logic signed [ACC_WIDTH-1:0]  acc_q [0:SIZE-1][0:SIZE-1];
  logic signed [ACC_WIDTH-1:0]  acc_d [0:SIZE-1][0:SIZE-1];
  logic [IDX_W-1:0]            ne_in;
  logic [KW-1:0]               k_idx;

  // Full-precision signed product, sign-extended (or wrapped) to the
  // accumulator width. The 2*DATA_WIDTH assignment context makes the
  // multiply produce every product bit before the resize.
  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = x * y;
    return ACC_WIDTH'(p);
  endfunction

  // Requested dimension clamped to the physical array; 0 stays 0.
  always_comb begin
    if (matrix_size > SIZE_8) ne_in = IDX_W'(SIZE);
    else                      ne_in = IDX_W'(matrix_size);
  end

  assign k_idx = k_q[KW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    ne_d    = ne_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end

      LOAD: begin
        // Snapshot the operands so later input changes cannot disturb
        // the running multiply.
        a_d  = matrix_a;
        b_d  = matrix_b;
        ne_d = ne_in;
        k_d  = '0;
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) begin
            acc_d[i][j] = '0;
          end
        end
        state_d = (ne_in == '0) ? FINISH : COMPUTE;
      end

      COMPUTE: begin
        // One outer-product step: column k of A times row k of B, added
        // into every active cell in parallel. Inactive cells keep their
        // cleared value.
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) begin
            if ((IDX_W'(i) < ne_q) && (IDX_W'(j) < ne_q)) begin
              acc_d[i][j] = acc_q[i][j] + mac_term(a_q[i][k_idx], b_q[k_idx][j]);
            end
          end
        end
        k_d = k_q + 1'b1;
        if (k_q == ne_q - 1'b1) state_d = FINISH;
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered rather than the current one.
    busy_d = (state_d == LOAD) || (state_d == COMPUTE);
    done_d = (state_d == FINISH);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ne_q    <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the operand and accumulator arrays are reset explicitly: an
      // aborted multiply must leave matrix_c and the operand snapshot at 0,
      // not just the control state.
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values computed above regardless of statement order.
      state_q <= state_d;
      ne_q    <= ne_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign matrix_c = acc_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tpu_simple.sv
// -----------------------------------------------------------------------------
// tb_tpu_simple
//
// Directed bench for tpu_simple (SIZE=4, DATA_WIDTH=8, ACC_WIDTH=32).
// Each operation pushes its expected result matrix, latency and busy length
// into scoreboard queues when start is driven; they are popped and compared
// when done is seen.
// -----------------------------------------------------------------------------
module tb_tpu_simple;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic        [7:0] msize = 8'd0;
  logic signed [7:0]  mat_a [0:N-1][0:N-1];
  logic signed [7:0]  mat_b [0:N-1][0:N-1];
  logic signed [31:0] mat_c [0:N-1][0:N-1];
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lat_q[$];
  int bsy_q[$];

  tpu_simple #(.SIZE(N), .DATA_WIDTH(8), .ACC_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_size (msize),
    .matrix_a    (mat_a),
    .matrix_b    (mat_b),
    .matrix_c    (mat_c),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'sd0;
        mat_b[i][j] = 8'sd0;
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'($urandom);
        mat_b[i][j] = 8'($urandom);
      end
  endtask

  task automatic b_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat_b[i][j] = (i == j) ? 8'sd1 : 8'sd0;
  endtask

  function automatic int nonzero_cells();
    int nz = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat_c[i][j] != 0) nz++;
    return nz;
  endfunction

  // Reference model: plain integer matrix product over the clamped block.
  task automatic push_expected(input int size);
    int ne;
    int s;
    ne = (size > N) ? N : size;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        if (i < ne && j < ne)
          for (int k = 0; k < ne; k++)
            s += int'(mat_a[i][k]) * int'(mat_b[k][j]);
        exp_q.push_back(s);
      end
    lat_q.push_back(ne + 2);
    bsy_q.push_back(ne + 1);
  endtask

  // Edges are counted from the one that samples start (edge 1).
  task automatic run_op(input int size, input bit pulse_mid, input bit scramble,
                        input string name);
    int  edges;
    int  busy_cnt;
    bit  got_done;
    int  exp_lat;
    int  exp_bsy;
    @(negedge clk);
    msize = 8'(size);
    push_expected(size);
    start = 1'b1;
    edges = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    while (!got_done && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) start = 1'b0;
      if (pulse_mid && edges == 3) start = 1'b1;
      if (pulse_mid && edges == 4) start = 1'b0;
      if (scramble && edges == 2) begin
        rand_mats();
        msize = 8'd1;
      end
      if (done) got_done = 1'b1;
      else if (busy) busy_cnt++;
    end
    exp_lat = lat_q.pop_front();
    exp_bsy = bsy_q.pop_front();
    if (!got_done) begin
      check({name, " done timeout"}, 0, 1);
      for (int c = 0; c < N * N; c++) void'(exp_q.pop_front());
    end else begin
      check({name, " latency"}, edges, exp_lat);
      check({name, " busy cycles"}, busy_cnt, exp_bsy);
      check({name, " busy during done"}, int'(busy), 0);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          check($sformatf("%s c[%0d][%0d]", name, i, j), mat_c[i][j], exp_q.pop_front());
      @(negedge clk);
      check({name, " done width"}, int'(done), 0);
      check({name, " idle after"}, int'(busy), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int done_seen;
    clear_mats();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset c zero", nonzero_cells(), 0);

    // Basic 2x2
    mat_a[0][0] = 8'sd1; mat_a[0][1] = 8'sd2; mat_a[1][0] = 8'sd3; mat_a[1][1] = 8'sd4;
    mat_b[0][0] = 8'sd5; mat_b[0][1] = 8'sd6; mat_b[1][0] = 8'sd7; mat_b[1][1] = 8'sd8;
    mat_a[2][2] = 8'sd9; mat_b[3][3] = 8'sd9;   // outside the active block
    run_op(2, 1'b0, 1'b0, "basic");
    check("basic c00 const", mat_c[0][0], 19);
    check("basic c11 const", mat_c[1][1], 50);
    check("basic held", mat_c[1][0], 43);

    // Identity after reset
    do_reset();
    @(negedge clk);
    check("reset2 c zero", nonzero_cells(), 0);
    clear_mats();
    mat_a[0][0] = 8'sd5; mat_a[0][1] = 8'sd6; mat_a[1][0] = 8'sd7; mat_a[1][1] = 8'sd8;
    b_identity();
    run_op(2, 1'b0, 1'b0, "ident");
    check("ident c01 const", mat_c[0][1], 6);

    // Signed extremes, full size
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = -8'sd128;
        mat_b[i][j] = -8'sd128;
      end
    run_op(4, 1'b0, 1'b0, "neg128");
    check("neg128 c33 const", mat_c[3][3], 65536);

    rand_mats();
    mat_a[0][0] = 8'sd1; mat_a[0][1] = -8'sd1; mat_a[0][2] = 8'sd2; mat_a[0][3] = -8'sd2;
    b_identity();
    run_op(4, 1'b0, 1'b0, "row0");
    check("row0 c03 const", mat_c[0][3], -2);

    // Size clamping
    rand_mats();
    run_op(7, 1'b0, 1'b0, "size7");
    rand_mats();
    run_op(0, 1'b0, 1'b0, "size0");

    // Reset in the middle of COMPUTE
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'sd3;
        mat_b[i][j] = 8'sd5;
      end
    @(negedge clk);
    msize = 8'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort busy before", int'(busy), 1);
    check("abort c nonzero before", int'(nonzero_cells() > 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort c zero", nonzero_cells(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort no done", done_seen, 0);
    check("abort idle", int'(busy), 0);
    rand_mats();
    run_op(4, 1'b0, 1'b0, "after abort");

    // Handshake: start during COMPUTE ignored, inputs changed after LOAD
    rand_mats();
    run_op(4, 1'b1, 1'b0, "start mid");
    rand_mats();
    run_op(3, 1'b0, 1'b1, "scramble");
    rand_mats();
    run_op(4, 1'b1, 1'b1, "both");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
